lcd_device: RTL and testbench
=============================

LCD_DEVICE -- requirements
Module: lcd_device

Interface
REQ-001 Parameter clk_mhz, default 240: CLK frequency in MHz, used to scale execution times.
REQ-002 Parameter exec_us, default 40: execution time in us for every accepted write except clear.
REQ-003 Parameter clear_us, default 1640: execution time in us for the clear-display command.
REQ-004 CLK  input  1  system clock, shared with the bus initiator.
REQ-005 RST  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 rs  input  1  register select: 0 = instruction/status, 1 = data.
REQ-007 rw  input  1  1 = read, 0 = write.
REQ-008 e  input  1  enable strobe.
REQ-009 LCD_DATA  inout  4  HD44780 upper-nibble bus (DB7..DB4).
REQ-010 rd_addr  input  7  host readback address into display RAM.
REQ-011 rd_data  output  8  registered display RAM byte at rd_addr, valid 1 cycle after rd_addr.
REQ-012 mode4  output  1  1 once the 4-bit interface is selected.
REQ-013 err  output  1  sticky flag: a write was attempted while busy.

Function
REQ-014 Register rs, rw, e and LCD_DATA every CLK; the falling edge of registered e is the write/commit strobe.
REQ-015 Drive LCD_DATA only while registered e=1 and rw=1; otherwise the bus is high-Z.
REQ-016 States: s_mode8 (reset state), s_hi (expect high nibble), s_lo (expect low nibble).
REQ-017 In s_mode8, an e-fall with rs=0 and rw=0 forms command {LCD_DATA,4'h0}.
REQ-018 In s_mode8, a formed command with DL (LCD_DATA[0]) = 0 moves to s_hi and sets mode4; DL = 1 stays in s_mode8.
REQ-019 In s_mode8, e-falls with rs=1 are ignored.
REQ-020 In s_hi, an e-fall latches the high nibble and moves to s_lo; in s_lo, an e-fall completes the byte and moves to s_hi.
REQ-021 In s_hi/s_lo, reads toggle nibble phase in the same way as writes.
REQ-022 Status read (rs=0, rw=1) drives {BF, AC[6:4]} in s_hi/s_mode8 and AC[3:0] in s_lo.
REQ-023 Data read (rs=1, rw=1) drives RAM[AC][7:4] and then RAM[AC][3:0]; AC steps on the low-nibble e-fall.
REQ-024 Instruction decode on completed write byte b, first match wins:
  - 0x01 clear: fill all 128 RAM bytes with 0x20 at 1 byte/CLK, then AC=0, I/D=1.
  - 0x02-0x03 home: AC=0.
  - 0x04-0x07 entry mode: I/D=b[1].
  - 0x80-0xFF: AC=b[6:0].
  - others: no state change, busy only.
REQ-025 Data write (rs=1) stores b at RAM[AC], then AC steps by +1 if I/D=1, else -1.
REQ-026 AC is 7 bits and wraps modulo 128 in both directions (0x7F+1=0x00, 0x00-1=0x7F).
REQ-027 A completed write while BF=1 is discarded, sets err and still advances nibble phase.
REQ-028 rd_data reads through a second RAM port, independent of bus activity, including during clear.

Reset
REQ-029 RST low asynchronously forces:
  - state s_mode8;
  - AC=0, I/D=1, BF=0, busy counter=0;
  - mode4=0, err=0, rd_data=0x00;
  - LCD_DATA high-Z.
REQ-030 RAM contents are undefined after reset until a clear.
REQ-031 RST asserted mid-clear or mid-byte abandons the operation; no partial nibble is retained.

Configuration
REQ-032 Macro LCD_DEVICE_BUSY_EN is defined: every accepted write loads the busy counter with clk_mhz*exec_us (clear: clk_mhz*clear_us), and BF=1 while the counter is nonzero.
REQ-033 Macro LCD_DEVICE_BUSY_EN is undefined: BF is constant 0, err never sets, and clear still takes 128 CLK, writes during which are ignored silently.

Verification
REQ-034 clk_mhz=1, exec_us=2: nibbles 0x3,0x3,0x3,0x2 with e pulses -> mode4=1, state s_hi.
REQ-035 4-bit mode, write 0x80|0x05, then data 0x41 -> RAM[0x05]=0x41 on rd_addr=0x05, and a status read returns AC=0x06.
REQ-036 Entry mode 0x04, AC=0x00, write data 0x55 -> AC=0x7F, RAM[0x00]=0x55.
REQ-037 Clear 0x01 -> BF=1 for clk_mhz*clear_us CLK; then rd_data=0x20 at addr 0x00 and at addr 0x7F, and AC=0.
REQ-038 Data write while BF=1 -> RAM unchanged, err=1; with the macro undefined, err stays 0.
REQ-039 RST low during clear at byte 40 -> all outputs at reset values, LCD_DATA high-Z; after release the state is s_mode8.

Source files
------------

// File: rtl/lcd_device_if.sv
// lcd_device_if: control strobes of the HD44780-style host bus (rs, rw, e).
// The 4-bit data bus stays a plain inout on the device so tristate
// resolution is done on an ordinary net.
`timescale 1ns/1ps
interface lcd_device_if;
  logic rs;
  logic rw;
  logic e;

  modport master (output rs, rw, e);
  modport slave  (input  rs, rw, e);
endinterface

// File: rtl/lcd_device.sv
// lcd_device: HD44780-style character display controller model.
// The host bus is sampled every CLK and a falling edge of the registered
// enable commits a nibble. Starts in 8-bit mode and switches to the 4-bit
// (two nibbles per byte) interface on a function-set with DL=0.
// Display RAM has 128 bytes plus a host readback port (rd_addr/rd_data).
// Optional feature macro: LCD_DEVICE_BUSY_EN enables the busy counter, BF
// and the err flag. Without it, BF is 0 and only the clear fill blocks writes.
`timescale 1ns/1ps
module lcd_device #(
  parameter int clk_mhz  = 240,
  parameter int exec_us  = 40,
  parameter int clear_us = 1640
) (
  input  logic        CLK,
  input  logic        RST,
  lcd_device_if.slave bus,
  inout  wire  [3:0]  LCD_DATA,
  input  logic [6:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        mode4,
  output logic        err
);

  typedef enum logic [1:0] {s_mode8, s_hi, s_lo} state_t;

  state_t      state;
  logic        e_p0, e_p1;
  logic        rs_p0, rs_p1;
  logic        rw_p0, rw_p1;
  logic [3:0]  dat_p0, dat_p1;

  logic [6:0]  ac;
  logic        id;
  logic [3:0]  hi_q;
  logic        clearing;
  logic [6:0]  clr_idx;
  logic        bf;

  logic [7:0]  mem [0:127];
  logic [7:0]  ram_ac;

  logic        fall;
  logic        wr_acc;
  logic [7:0]  wr_b;
  logic [6:0]  ac_step;
  logic        mem_we;
  logic [6:0]  mem_wa;
  logic [7:0]  mem_wd;
  logic [3:0]  drv;

`ifdef LCD_DEVICE_BUSY_EN
  localparam logic [31:0] EXEC_CYC  = 32'(clk_mhz * exec_us);
  localparam logic [31:0] CLEAR_CYC = 32'(clk_mhz * clear_us);
  logic [31:0] busy_cnt;
  assign bf = (busy_cnt != 32'd0);
`else
  logic unused_cfg;
  assign unused_cfg = ^{clk_mhz, exec_us, clear_us};
  assign bf = 1'b0;
`endif

  // Stage p0/p1: enable strobe history (control, reset so the bus floats)
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      e_p0 <= 1'b0;
      e_p1 <= 1'b0;
    end else begin
      e_p0 <= bus.e;
      e_p1 <= e_p0;
    end
  end

  // Stage p0/p1: rs, rw and data nibble aligned with the enable history
  always_ff @(posedge CLK) begin
    rs_p0  <= bus.rs;
    rs_p1  <= rs_p0;
    rw_p0  <= bus.rw;
    rw_p1  <= rw_p0;
    dat_p0 <= LCD_DATA;
    dat_p1 <= dat_p0;
  end

  // p1 values are the ones that were stable while e was still high
  assign fall    = e_p1 & ~e_p0;
  assign wr_acc  = ~bf & ~clearing;
  assign wr_b    = (state == s_mode8) ? {dat_p1, 4'h0} : {hi_q, dat_p1};
  assign ac_step = id ? (ac + 7'd1) : (ac - 7'd1);
  assign ram_ac  = mem[ac];

  // Bus FSM: nibble phase, instruction decode, address counter, flags
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= s_mode8;
      ac       <= 7'h00;
      id       <= 1'b1;
      hi_q     <= 4'h0;
      clearing <= 1'b0;
      clr_idx  <= 7'h00;
      mode4    <= 1'b0;
      err      <= 1'b0;
`ifdef LCD_DEVICE_BUSY_EN
      busy_cnt <= 32'd0;
`endif
    end else begin
`ifdef LCD_DEVICE_BUSY_EN
      if (bf) busy_cnt <= busy_cnt - 32'd1;
`endif
      if (clearing) begin
        clr_idx <= clr_idx + 7'd1;
        if (clr_idx == 7'h7F) begin
          clearing <= 1'b0;
          ac       <= 7'h00;
          id       <= 1'b1;
        end
      end
      if (fall) begin
        if (rw_p1) begin
          // reads only move the nibble phase; a data read steps AC on its low half
          if (state == s_hi) begin
            state <= s_lo;
          end else if (state == s_lo) begin
            state <= s_hi;
            if (rs_p1) ac <= ac_step;
          end
        end else if (state == s_hi) begin
          hi_q  <= dat_p1;
          state <= s_lo;
        end else if (state == s_lo || !rs_p1) begin
          if (state == s_lo) state <= s_hi;
          if (wr_acc) begin
            if (state == s_mode8 && !dat_p1[0]) begin
              state <= s_hi;
              mode4 <= 1'b1;
            end
`ifdef LCD_DEVICE_BUSY_EN
            busy_cnt <= (!rs_p1 && wr_b == 8'h01) ? CLEAR_CYC : EXEC_CYC;
`endif
            if (rs_p1) begin
              ac <= ac_step;
            end else if (wr_b == 8'h01) begin
              clearing <= 1'b1;
              clr_idx  <= 7'h00;
            end else if (wr_b[7:1] == 7'h01) begin
              ac <= 7'h00;
            end else if (wr_b[7:2] == 6'h01) begin
              id <= wr_b[1];
            end else if (wr_b[7]) begin
              ac <= wr_b[6:0];
            end
          end else if (bf) begin
            err <= 1'b1;
          end
        end
      end
    end
  end

  // RAM write select: the clear fill owns the port while it runs
  always_comb begin
    mem_we = 1'b0;
    mem_wa = ac;
    mem_wd = wr_b;
    if (clearing) begin
      mem_we = 1'b1;
      mem_wa = clr_idx;
      mem_wd = 8'h20;
    end else if (fall && !rw_p1 && rs_p1 && state == s_lo && wr_acc) begin
      mem_we = 1'b1;
    end
  end

  // Display RAM write port
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Host readback port, independent of bus traffic
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rd_data <= 8'h00;
    else      rd_data <= mem[rd_addr];
  end

  // Read nibble: high half (or BF/AC[6:4]) first, low half in s_lo
  always_comb begin
    drv = 4'h0;
    if (state == s_lo) drv = rs_p0 ? ram_ac[3:0] : ac[3:0];
    else               drv = rs_p0 ? ram_ac[7:4] : {bf, ac[6:4]};
  end

  assign LCD_DATA = (e_p0 && rw_p0) ? drv : 4'bzzzz;

endmodule

// File: tb/tb_lcd_device.sv
// tb_lcd_device: directed scoreboard bench for lcd_device.
// Expected bytes are queued when a step is driven and popped when the
// matching DUT output is sampled.
`timescale 1ns/1ps
module tb_lcd_device;
  localparam int CLK_MHZ   = 1;
  localparam int EXEC_US   = 2;
  localparam int CLEAR_US  = 200;
  localparam int CLEAR_CYC = CLK_MHZ * CLEAR_US;
`ifdef LCD_DEVICE_BUSY_EN
  localparam logic BUSY = 1'b1;
`else
  localparam logic BUSY = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       tb_drv = 1'b0;
  logic [3:0] tb_val = 4'h0;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] rd_data;
  logic       mode4;
  logic       err;
  wire  [3:0] lcd_data;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] sb [$];

  lcd_device_if bus ();

  assign lcd_data = tb_drv ? tb_val : 4'bzzzz;
  pullup (lcd_data);

  always #5 CLK = ~CLK;

  lcd_device #(.clk_mhz(CLK_MHZ), .exec_us(EXEC_US), .clear_us(CLEAR_US)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .LCD_DATA (lcd_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .mode4    (mode4),
    .err      (err)
  );

  task automatic expect_v(input logic [7:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs);
    logic [7:0] exp_v;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      exp_v = sb.pop_front();
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
    end
  endtask

  // one enable pulse; q is the bus value seen while e is high
  task automatic pulse(input logic r_s, input logic r_w, input logic [3:0] d,
                       output logic [3:0] q);
    @(negedge CLK);
    bus.rs = r_s;
    bus.rw = r_w;
    tb_drv = ~r_w;
    tb_val = d;
    bus.e  = 1'b1;
    repeat (3) @(negedge CLK);
    q = lcd_data;
    bus.e = 1'b0;
    repeat (3) @(negedge CLK);
    tb_drv = 1'b0;
    bus.rw = 1'b0;
  endtask

  task automatic wr_byte(input logic r_s, input logic [7:0] b);
    logic [3:0] unused_q;
    pulse(r_s, 1'b0, b[7:4], unused_q);
    pulse(r_s, 1'b0, b[3:0], unused_q);
  endtask

  task automatic rd_byte(input logic r_s, output logic [7:0] v);
    logic [3:0] h, l;
    pulse(r_s, 1'b1, 4'h0, h);
    pulse(r_s, 1'b1, 4'h0, l);
    v = {h, l};
  endtask

  task automatic rd_ram(input logic [6:0] a, output logic [7:0] v);
    @(negedge CLK);
    rd_addr = a;
    repeat (2) @(negedge CLK);
    v = rd_data;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [3:0] q;
    bus.rs = 1'b0;
    bus.rw = 1'b0;
    bus.e  = 1'b0;

    // reset values
    #2 RST = 1'b0;
    #1;
    expect_v(8'h00); chk("rst_mode4", {7'h0, mode4});
    expect_v(8'h00); chk("rst_err", {7'h0, err});
    expect_v(8'h00); chk("rst_rd_data", rd_data);
    expect_v(8'h0F); chk("rst_bus_z", {4'h0, lcd_data});
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    // 8-bit mode: rs=1 ignored, DL=1 stays, DL=0 selects 4-bit
    pulse(1'b1, 1'b0, 4'h2, q);
    expect_v(8'h00); chk("mode8_rs1_ignored", {7'h0, mode4});
    pulse(1'b0, 1'b0, 4'h3, q);
    pulse(1'b0, 1'b0, 4'h3, q);
    pulse(1'b0, 1'b0, 4'h3, q);
    expect_v(8'h00); chk("mode8_dl1_stays", {7'h0, mode4});
    pulse(1'b0, 1'b0, 4'h2, q);
    expect_v(8'h01); chk("init_mode4", {7'h0, mode4});

    // set AC, write data, read back both ways
    wr_byte(1'b0, 8'h85);
    wr_byte(1'b1, 8'h41);
    rd_ram(7'h05, v);
    expect_v(8'h41); chk("ram05_41", v);
    rd_byte(1'b0, v);
    expect_v(8'h06); chk("status_ac06", v);
    wr_byte(1'b0, 8'h85);
    rd_byte(1'b1, v);
    expect_v(8'h41); chk("data_read_41", v);
    rd_byte(1'b0, v);
    expect_v(8'h06); chk("status_after_dread", v);

    // clear: BF during fill, then spaces everywhere and AC=0
    wr_byte(1'b0, 8'h01);
    repeat (8) @(negedge CLK);
    rd_byte(1'b0, v);
    expect_v({BUSY, 3'b000, 4'h6}); chk("clear_bf", v);
    repeat (CLEAR_CYC + 20) @(negedge CLK);
    rd_ram(7'h00, v);
    expect_v(8'h20); chk("clear_ram00", v);
    rd_ram(7'h7F, v);
    expect_v(8'h20); chk("clear_ram7f", v);
    rd_byte(1'b0, v);
    expect_v(8'h00); chk("clear_status", v);

    // decrement entry mode and AC wrap in both directions
    wr_byte(1'b0, 8'h04);
    wr_byte(1'b1, 8'h55);
    rd_byte(1'b0, v);
    expect_v(8'h7F); chk("dec_wrap_ac", v);
    rd_ram(7'h00, v);
    expect_v(8'h55); chk("dec_ram00", v);
    wr_byte(1'b1, 8'hAA);
    rd_ram(7'h7F, v);
    expect_v(8'hAA); chk("dec_ram7f", v);
    rd_byte(1'b0, v);
    expect_v(8'h7E); chk("dec_ac7e", v);
    wr_byte(1'b0, 8'h06);
    wr_byte(1'b0, 8'hFF);
    wr_byte(1'b1, 8'h11);
    rd_byte(1'b0, v);
    expect_v(8'h00); chk("inc_wrap_ac", v);
    rd_ram(7'h7F, v);
    expect_v(8'h11); chk("inc_ram7f", v);
    wr_byte(1'b0, 8'h85);
    wr_byte(1'b0, 8'h02);
    rd_byte(1'b0, v);
    expect_v(8'h00); chk("home_ac", v);
    expect_v(8'h00); chk("err_idle", {7'h0, err});

    // write attempted during clear: discarded, err only with busy logic
    wr_byte(1'b0, 8'h85);
    wr_byte(1'b0, 8'h01);
    repeat (30) @(negedge CLK);
    rd_byte(1'b0, v);
    expect_v({BUSY, 3'b000, 4'h5}); chk("busy_status", v);
    wr_byte(1'b1, 8'h99);
    expect_v({7'h0, BUSY}); chk("busy_err", {7'h0, err});
    repeat (CLEAR_CYC + 20) @(negedge CLK);
    rd_ram(7'h05, v);
    expect_v(8'h20); chk("busy_ram_unchanged", v);
    rd_byte(1'b0, v);
    expect_v(8'h00); chk("busy_done_status", v);

    // reset in the middle of a clear
    wr_byte(1'b0, 8'h01);
    repeat (40) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    expect_v(8'h00); chk("midclr_mode4", {7'h0, mode4});
    expect_v(8'h00); chk("midclr_err", {7'h0, err});
    expect_v(8'h00); chk("midclr_rd_data", rd_data);
    expect_v(8'h0F); chk("midclr_bus_z", {4'h0, lcd_data});
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    pulse(1'b0, 1'b0, 4'h2, q);
    expect_v(8'h01); chk("post_rst_mode8", {7'h0, mode4});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
